// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four packet requesters feeding one shared 4:1 select datapath.
// The granted requester's beats go out through a registered valid/ready output stage.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       ack,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int unsigned CntW = $clog2(MAX_BEATS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BEATS - 1);

  localparam logic StIdle  = 1'b0;
  localparam logic StGrant = 1'b1;

  logic             state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             found;
  logic [WIDTH-1:0] din_s;
  logic             space;
  logic             take;
  logic             beat_last;

  // First requesting index at or after ptr, wrapping modulo 4.
  always_comb begin
    pick  = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (sel_q)
      2'd0: din_s = din0;
      2'd1: din_s = din1;
      2'd2: din_s = din2;
      2'd3: din_s = din3;
    endcase
  end

  assign space     = ~out_valid_q | out_ready;
  assign take      = (state_q == StGrant) & req[sel_q] & space & ~rst;
  assign beat_last = last[sel_q] | (cnt_q == CntMax);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (take) begin
          if (beat_last) begin
            state_d = StIdle;
            gnt_d   = '0;
            ptr_d   = sel_q + 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = din_s;
      out_last_d  = beat_last;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign ack       = take ? (4'b0001 << sel_q) : 4'b0000;
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = (state_q == StGrant);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized bench for rr_mux_arbiter, compared every cycle against a behavioural
// model that tracks the owner, pointer, beat count and output register as integers.
module tb_rr_mux_arbiter;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned MAXB  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       last;
  logic [WIDTH-1:0] din [4];
  logic [3:0]       ack;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .din0      (din[0]),
    .din1      (din[1]),
    .din2      (din[2]),
    .din3      (din[3]),
    .ack       (ack),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: owner = -1 when nobody holds the grant.
  int         owner, ptr, cnt, msel;
  bit         ov, ol;
  logic [7:0] od;
  // Per-requester beat source: beat number and whether that beat ends its packet.
  int         seq [4];
  bit         lst [4];
  int         prob_req, prob_rdy, prob_last, prob_rst;

  task automatic model_reset();
    owner = -1; ptr = 0; cnt = 0; msel = 0; ov = 0; ol = 0; od = '0;
  endtask

  task automatic cycle();
    bit mack, space, pk;
    @(negedge clk);
    rst = ($urandom_range(999) < prob_rst);
    for (int i = 0; i < 4; i++) begin
      req[i]  = ($urandom_range(99) < prob_req);
      last[i] = lst[i];
      din[i]  = 8'((i << 6) | (seq[i] & 63));
    end
    out_ready = ($urandom_range(99) < prob_rdy);
    #1;
    space = !ov || out_ready;
    mack  = !rst && (owner >= 0) && req[owner] && space;
    check_eq("ack", ack, mack ? (32'd1 << owner) : 32'd0);
    check_eq("gnt", gnt, (owner >= 0) ? (32'd1 << owner) : 32'd0);
    check_eq("sel", sel, msel);
    check_eq("busy", busy, owner >= 0);
    check_eq("out_valid", out_valid, ov);
    check_eq("out_data", out_data, od);
    check_eq("out_last", out_last, ol);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (mack) begin
        od = din[owner];
        ov = 1;
        ol = last[owner] || (cnt == MAXB - 1);
      end else if (ov && out_ready) begin
        ov = 0;
      end
      if (owner < 0) begin
        pk = 0;
        for (int k = 0; k < 4; k++) begin
          if (!pk && req[(ptr + k) % 4]) begin
            owner = (ptr + k) % 4;
            msel  = owner;
            cnt   = 0;
            pk    = 1;
          end
        end
      end else if (mack) begin
        seq[owner]++;
        lst[owner] = ($urandom_range(99) < prob_last);
        if (ol) begin
          ptr   = (owner + 1) % 4;
          owner = -1;
          cnt   = 0;
        end else begin
          cnt++;
        end
      end
    end
  endtask

  task automatic phase(input int n, input int preq, input int prdy, input int plast,
                       input int prst);
    prob_req = preq; prob_rdy = prdy; prob_last = plast; prob_rst = prst;
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[i] = '0; seq[i] = 0; lst[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    model_reset();
    // All requesting with single-beat packets: strict rotation with bubbles.
    phase(40, 100, 100, 100, 0);
    // Mixed traffic, backpressure and request gaps.
    phase(800, 70, 70, 30, 0);
    // Long packets: forced release after MAXB beats.
    phase(800, 85, 60, 5, 0);
    // Occasional reset mid-traffic.
    phase(600, 75, 65, 25, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
